// File: rtl/ysyx_23060337_core_ctrl_if.sv
// Handshake and status bundle between the core sequencer and its IFU, LSU,
// decoder and datapath. The sequencer is the master side.
interface ysyx_23060337_core_ctrl_if #(
    parameter int CNT_W = 64
);
    logic             ifu_req;
    logic             ifu_ack;
    logic             ifu_err;
    logic             inst_we;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             lsu_req;
    logic             lsu_wen;
    logic             lsu_ack;
    logic             lsu_err;
    logic             rf_we;
    logic             pc_we;
    logic             halt;
    logic [1:0]       trap_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        output ifu_req, inst_we, lsu_req, lsu_wen, rf_we, pc_we,
               halt, trap_code, cycle_cnt, instret_cnt,
        input  ifu_ack, ifu_err, opcode, funct3, lsu_ack, lsu_err
    );

    modport slave (
        input  ifu_req, inst_we, lsu_req, lsu_wen, rf_we, pc_we,
               halt, trap_code, cycle_cnt, instret_cnt,
        output ifu_ack, ifu_err, opcode, funct3, lsu_ack, lsu_err
    );
endinterface

// File: rtl/ysyx_23060337_core_ctrl.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC/MEM -> WB, with bus-timeout,
// ebreak and illegal-opcode traps into a sticky HALT, plus cycle/instret counters.
module ysyx_23060337_core_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ysyx_23060337_core_ctrl_if.master bus
);
    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] TRAP_EBREAK  = 2'd1;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
    localparam logic [1:0] TRAP_BUS     = 2'd3;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [1:0]       trap_q, trap_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             wait_hit_s;

    assign wait_hit_s = (wait_q == TIMEOUT_W);

    // Next state; trap code is captured only on the transition into HALT
    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.ifu_err) begin
                    state_d = S_HALT;
                    trap_d  = TRAP_BUS;
                end else if (bus.ifu_ack) begin
                    state_d = S_DECODE;
                end else if (wait_hit_s) begin
                    state_d = S_HALT;
                    trap_d  = TRAP_BUS;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_SYSTEM: begin
                        state_d = S_HALT;
                        trap_d  = (bus.funct3 == 3'b000) ? TRAP_EBREAK : TRAP_ILLEGAL;
                    end
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_OPIMM, OP_OP:
                        state_d = S_EXEC;
                    default: begin
                        state_d = S_HALT;
                        trap_d  = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: state_d = S_WB;
            S_MEM: begin
                if (bus.lsu_err) begin
                    state_d = S_HALT;
                    trap_d  = TRAP_BUS;
                end else if (bus.lsu_ack) begin
                    state_d = S_WB;
                end else if (wait_hit_s) begin
                    state_d = S_HALT;
                    trap_d  = TRAP_BUS;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB:   state_d = S_FETCH;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Wait counter only runs while staying in a bus state; any other path clears it
    always_comb begin
        if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q)) begin
            wait_d = wait_hit_s ? wait_q : (wait_q + 16'd1);
        end else begin
            wait_d = 16'd0;
        end
    end

    // Performance counters, frozen in RST and HALT
    always_comb begin
        if ((state_q != S_RST) && (state_q != S_HALT)) begin
            cycle_d = cycle_q + CNT_W'(1);
        end else begin
            cycle_d = cycle_q;
        end
        if (state_q == S_WB) begin
            instret_d = instret_q + CNT_W'(1);
        end else begin
            instret_d = instret_q;
        end
    end

    // State, trap, wait and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            trap_q    <= 2'd0;
            wait_q    <= 16'd0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            wait_q    <= wait_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Outputs decode from the state register so reset drops requests at once
    assign bus.ifu_req     = (state_q == S_FETCH);
    assign bus.inst_we     = (state_q == S_FETCH) && bus.ifu_ack && !bus.ifu_err;
    assign bus.lsu_req     = (state_q == S_MEM);
    assign bus.lsu_wen     = (state_q == S_MEM) && (bus.opcode == OP_STORE);
    assign bus.pc_we       = (state_q == S_WB);
    assign bus.rf_we       = (state_q == S_WB) && (bus.opcode != OP_STORE)
                                               && (bus.opcode != OP_BRANCH);
    assign bus.halt        = (state_q == S_HALT);
    assign bus.trap_code   = trap_q;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;
endmodule
